// File: rtl/uart_tx_if.sv
// Write-side handshake between the APB register block and the UART transmitter:
// TX-data write strobe, the byte being written, and FIFO-space feedback.
interface uart_tx_if;
    logic       tx_data_reg_wr;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_data_reg_wr,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_data_reg_wr,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO fed by the register block, internal 16x baud timing,
// start / 7-or-8 data / optional parity / one stop bit framing on a registered txd.
module uart_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        PCLK,
    input  logic        PRESET,
    uart_tx_if.slave    bus,
    input  logic [12:0] baud_val,
    input  logic        data_bits,
    input  logic        parity_en,
    input  logic        parity_odd0_even1,
    output logic        tx_busy,
    output logic        txd
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CONE_C  = CW'(1);
    localparam logic [CW-1:0] CZERO_C = CW'(0);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic parity_fn(input logic [7:0] d, input logic eight, input logic even);
        logic x;
        x = (^d[6:0]) ^ (eight & d[7]);
        return even ? x : ~x;
    endfunction

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          tx_ready_r;
    logic          wr_en_s;
    logic          pop_s;
    logic          not_empty_s;
    logic          bit_end_s;
    logic [7:0]    fifo_dout_s;
    logic [2:0]    last_bit_s;

    state_t        state_r;
    logic [12:0]   presc_r;
    logic [3:0]    tick_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic [12:0]   baud_r;
    logic          bits8_r;
    logic          par_en_r;
    logic          par_bit_r;
    logic          txd_r;
    logic          busy_r;

    assign bus.tx_ready = tx_ready_r;
    assign tx_busy      = busy_r;
    assign txd          = txd_r;

    assign fifo_dout_s = mem_r[rd_ptr_r];
    assign not_empty_s = (count_r != CZERO_C);
    assign wr_en_s     = bus.tx_data_reg_wr & tx_ready_r;
    assign bit_end_s   = (presc_r == baud_r) && (tick_r == 4'hF);
    assign last_bit_s  = bits8_r ? 3'd7 : 3'd6;

    // Pop decision: from IDLE, or at the last cycle of a stop bit for contiguous frames.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = not_empty_s;
            ST_STOP: begin
                if (bit_end_s) begin
                    pop_s = not_empty_s;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: pop_s = 1'b0;
        endcase
    end

    // Next FIFO occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + CONE_C;
            2'b01:   count_nxt_s = count_r - CONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage; writes while full never reach here because wr_en_s is gated.
    always_ff @(posedge PCLK) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= bus.tx_data;
        end
    end

    // FIFO pointers, count and the registered space flag.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= CZERO_C;
            tx_ready_r <= 1'b1;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PONE_C;
            end
            count_r    <= count_nxt_s;
            tx_ready_r <= (count_nxt_s != FULL_C);
        end
    end

    // Framing FSM with bit timing; frame settings are captured at each pop.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r   <= ST_IDLE;
            presc_r   <= 13'd0;
            tick_r    <= 4'd0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
            baud_r    <= 13'd0;
            bits8_r   <= 1'b0;
            par_en_r  <= 1'b0;
            par_bit_r <= 1'b0;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            if (presc_r == baud_r) begin
                presc_r <= 13'd0;
                tick_r  <= tick_r + 4'd1;
            end else begin
                presc_r <= presc_r + 13'd1;
            end

            case (state_r)
                ST_IDLE: begin
                    presc_r <= 13'd0;
                    tick_r  <= 4'd0;
                    if (pop_s) begin
                        shift_r   <= fifo_dout_s;
                        baud_r    <= baud_val;
                        bits8_r   <= data_bits;
                        par_en_r  <= parity_en;
                        par_bit_r <= parity_fn(fifo_dout_s, data_bits, parity_odd0_even1);
                        state_r   <= ST_START;
                        txd_r     <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        txd_r  <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        presc_r   <= 13'd0;
                        tick_r    <= 4'd0;
                        bit_cnt_r <= 3'd0;
                        state_r   <= ST_DATA;
                        txd_r     <= shift_r[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        presc_r <= 13'd0;
                        tick_r  <= 4'd0;
                        if (bit_cnt_r == last_bit_s) begin
                            if (par_en_r) begin
                                state_r <= ST_PARITY;
                                txd_r   <= par_bit_r;
                            end else begin
                                state_r <= ST_STOP;
                                txd_r   <= 1'b1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            txd_r     <= shift_r[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        presc_r <= 13'd0;
                        tick_r  <= 4'd0;
                        state_r <= ST_STOP;
                        txd_r   <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        presc_r <= 13'd0;
                        tick_r  <= 4'd0;
                        if (pop_s) begin
                            shift_r   <= fifo_dout_s;
                            baud_r    <= baud_val;
                            bits8_r   <= data_bits;
                            par_en_r  <= parity_en;
                            par_bit_r <= parity_fn(fifo_dout_s, data_bits, parity_odd0_even1);
                            state_r   <= ST_START;
                            txd_r     <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            txd_r   <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    txd_r   <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule
